alu_slice_sequencer: RTL and testbench

ALU_SLICE_SEQUENCER -- requirements
Module: alu_slice_sequencer

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_4bit.sv | 49 ++++
 rtl/alu_slice_sequencer.sv | 100 ++++++++++
 tb/tb_alu_slice_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the slice-sequenced ALU: FSM encoding and slice width.
package alu_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_4bit.sv
// 4-bit slice ALU. Active-high data, active-low carry in/out. Logic mode ignores carry.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic [3:0]         i_s,
  input  logic               i_m,
  input  logic               i_cn,
  output logic [SLICE_W-1:0] o_f,
  output logic               o_cn4
);
  logic [SLICE_W-1:0] w_p, w_g, w_sum, w_lg;
  logic [SLICE_W:0]   w_c;

  // S selects which of B / ~B feed propagate (S1:S0) and generate (S3:S2)
  always_comb begin
    w_p    = i_a | (i_b & {SLICE_W{i_s[0]}}) | (~i_b & {SLICE_W{i_s[1]}});
    w_g    = (i_a & i_b & {SLICE_W{i_s[3]}}) | (i_a & ~i_b & {SLICE_W{i_s[2]}});
    w_c    = '0;
    w_c[0] = ~i_cn;
    for (int i = 0; i < SLICE_W; i++) w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    w_sum  = w_p ^ w_g ^ w_c[SLICE_W-1:0];
  end

  always_comb begin
    case (i_s)
      4'b0000: w_lg = ~i_a;
      4'b0001: w_lg = ~(i_a | i_b);
      4'b0010: w_lg = ~i_a & i_b;
      4'b0011: w_lg = '0;
      4'b0100: w_lg = ~(i_a & i_b);
      4'b0101: w_lg = ~i_b;
      4'b0110: w_lg = i_a ^ i_b;
      4'b0111: w_lg = i_a & ~i_b;
      4'b1000: w_lg = i_a & i_b;
      4'b1001: w_lg = ~(i_a ^ i_b);
      4'b1010: w_lg = i_b;
      4'b1011: w_lg = ~i_a | i_b;
      4'b1100: w_lg = '1;
      4'b1101: w_lg = i_a | ~i_b;
      4'b1110: w_lg = i_a | i_b;
      default: w_lg = i_a;
    endcase
  end

  assign o_f   = i_m ? w_lg : w_sum;
  assign o_cn4 = i_m ? 1'b0 : ~w_c[SLICE_W];
endmodule

// File: rtl/alu_slice_sequencer.sv
// Wide ALU built by time-multiplexing one 4-bit slice ALU, LSB slice first, carry held in r_c.
module alu_slice_sequencer
  import alu_pkg::*;
#(
  parameter int NSLICE = 4,
  localparam int W  = SLICE_W * NSLICE,
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   s,
  input  logic         m,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output logic         cout,
  output logic         zero
);
  state_t              r_state, w_next;
  logic [KW-1:0]       r_k;
  logic                r_c, r_m, r_cout;
  logic [3:0]          r_s;
  logic [W-1:0]        r_a, r_b, r_o;
  logic [SLICE_W-1:0]  w_sa, w_sb, w_f;
  logic                w_cn4, w_last;

  assign w_last = (r_k == KW'(NSLICE - 1));
  assign w_sa   = r_a[SLICE_W*int'(r_k) +: SLICE_W];
  assign w_sb   = r_b[SLICE_W*int'(r_k) +: SLICE_W];

  alu_4bit u_slice (
    .i_a  (w_sa),
    .i_b  (w_sb),
    .i_s  (r_s),
    .i_m  (r_m),
    .i_cn (r_c),
    .o_f  (w_f),
    .o_cn4(w_cn4)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    o         = r_o;
    cout      = r_cout;
    zero      = (r_o == '0);
  end

  // Operands are captured only in IDLE, so input activity in RUN/DONE cannot disturb the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_c    <= 1'b1;
      r_o    <= '0;
      r_cout <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_s    <= '0;
      r_m    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a <= a;
          r_b <= b;
          r_s <= s;
          r_m <= m;
          r_c <= cin;
          r_k <= '0;
        end
        RUN: begin
          r_o[SLICE_W*int'(r_k) +: SLICE_W] <= w_f;
          r_c <= w_cn4;
          if (w_last) r_cout <= w_cn4;
          else        r_k    <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer with NSLICE=4 (16-bit operands).
module tb_alu_slice_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, m, cin, out_valid, out_ready, cout, zero;
  logic [15:0] a, b, o;
  logic [3:0]  s;
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat;

  always #5 clk = ~clk;

  alu_slice_sequencer #(.NSLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .cout(cout), .zero(zero)
  );

  // Wait for out_valid; lat counts cycles from the accept cycle (accept cycle = 0). Bounded.
  task automatic wait_done(input bit noise, output int l);
    l = 1;
    while (!out_valid && l < 40) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      l++;
    end
    in_valid = 1'b0;
  endtask

  // Present one request in an IDLE cycle, scramble inputs afterwards, wait for the result.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                        input logic tm, input logic tc, input bit noise, output int l);
    @(negedge clk);
    a = ta; b = tb; s = ts; m = tm; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta; b = ~tb; s = ~ts; m = ~tm; cin = ~tc;
    wait_done(noise, l);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; s = 4'hF; m = 1'b0; cin = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (o !== 16'h0000)      begin n_err++; $display("FAIL reset_o got %h want 0000", o); end
    n_cmp++; if (cout !== 1'b0)       begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
    n_cmp++; if (zero !== 1'b1)       begin n_err++; $display("FAIL reset_zero got %b want 1", zero); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    run_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 1'b0, lat);
    n_cmp++; if (lat != 5)            begin n_err++; $display("FAIL add_latency got %0d want 5", lat); end
    n_cmp++; if (o !== 16'h2201)      begin n_err++; $display("FAIL add_o got %h want 2201", o); end
    n_cmp++; if (cout !== 1'b1)       begin n_err++; $display("FAIL add_cout got %b want 1", cout); end
    n_cmp++; if (zero !== 1'b0)       begin n_err++; $display("FAIL add_zero got %b want 0", zero); end
    consume();
  endtask

  task automatic test_sub();
    run_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b0, 1'b0, lat);
    n_cmp++; if (o !== 16'h4FFF)      begin n_err++; $display("FAIL sub_o got %h want 4fff", o); end
    n_cmp++; if (cout !== 1'b0)       begin n_err++; $display("FAIL sub_cout got %b want 0", cout); end
    consume();
  endtask

  task automatic test_ripple();
    run_op(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b0, 1'b0, lat);
    n_cmp++; if (o !== 16'h0000)      begin n_err++; $display("FAIL ripple_o got %h want 0000", o); end
    n_cmp++; if (zero !== 1'b1)       begin n_err++; $display("FAIL ripple_zero got %b want 1", zero); end
    n_cmp++; if (cout !== 1'b0)       begin n_err++; $display("FAIL ripple_cout got %b want 0", cout); end
    consume();
  endtask

  task automatic test_logic_and();
    run_op(16'hF0F0, 16'hFF00, 4'b1000, 1'b1, 1'b0, 1'b1, lat);
    n_cmp++; if (lat != 5)            begin n_err++; $display("FAIL and_latency got %0d want 5", lat); end
    n_cmp++; if (o !== 16'hF000)      begin n_err++; $display("FAIL and_o got %h want f000", o); end
    n_cmp++; if (cout !== 1'b0)       begin n_err++; $display("FAIL and_cout got %b want 0", cout); end
    consume();
    n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL and_idle got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    run_op(16'h0F0F, 16'h00FF, 4'b1110, 1'b1, 1'b1, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (o !== 16'h0FFF || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cyc %0d o=%h vld=%b rdy=%b want 0fff 1 0", i, o, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL bp_release got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL bp_valid_drop got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    run_op(16'h00AA, 16'h0011, 4'b1001, 1'b0, 1'b1, 1'b0, lat);
    n_cmp++; if (o !== 16'h00BB)      begin n_err++; $display("FAIL b2b_first got %h want 00bb", o); end
    // New request offered on the handoff cycle must wait for IDLE
    out_ready = 1'b1; in_valid = 1'b1;
    a = 16'h0003; b = 16'h0004; s = 4'b1001; m = 1'b0; cin = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_handoff rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL b2b_accept got %b want 0", in_ready); end
    wait_done(1'b0, lat);
    n_cmp++; if (lat != 5)            begin n_err++; $display("FAIL b2b_latency got %0d want 5", lat); end
    n_cmp++; if (o !== 16'h0007 || cout !== 1'b1) begin
      n_err++; $display("FAIL b2b_second o=%h cout=%b want 0007 1", o, cout);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; s = 4'b1001; m = 1'b0; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);              // RUN k=0
    in_valid = 1'b0;
    @(negedge clk);              // RUN k=1
    @(negedge clk);              // RUN k=2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_state rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    n_cmp++; if (o !== 16'h0000 || zero !== 1'b1) begin
      n_err++; $display("FAIL midrst_o o=%h zero=%b want 0000 1", o, zero);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale cyc %0d got 1 want 0", i); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ripple();
    test_logic_and();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
